// File: rtl/decode_hazard_ctrl_pkg.sv
// Shared sizes and state encodings for the decode
// hazard controller and its scoreboard.
package decode_hazard_ctrl_pkg;

  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int CNT_WIDTH      = 8;
  localparam int STALL_LIMIT    = 255;

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [NUM_REGS-1:0]       reg_mask_t;
  typedef logic [CNT_WIDTH-1:0]      cnt_t;

  typedef enum logic [1:0] {
    HZ_RUN   = 2'd0,
    HZ_STALL = 2'd1,
    HZ_DRAIN = 2'd2
  } hz_state_e;

endpackage

// File: rtl/decode_hazard_ctrl_if.sv
// Decoder / writeback / downstream bundle seen
// by the hazard controller.
interface decode_hazard_ctrl_if;
  import decode_hazard_ctrl_pkg::*;

  logic      dec_valid;
  reg_addr_t dec_rs1;
  logic      dec_rs1_valid;
  reg_addr_t dec_rs2;
  logic      dec_rs2_valid;
  reg_addr_t dec_rd;
  logic      dec_rd_valid;
  logic      dec_is_system;
  logic      ex_stall;
  logic      wb_valid;
  reg_addr_t wb_rd;

  logic      issue;
  logic      system_stall;
  reg_mask_t busy_mask;
  logic [1:0] state;
  cnt_t      stall_cnt;
  logic      deadlock_err;
  logic      wb_err;

  modport master (
    output dec_valid, dec_rs1, dec_rs1_valid,
    output dec_rs2, dec_rs2_valid,
    output dec_rd, dec_rd_valid, dec_is_system,
    output ex_stall, wb_valid, wb_rd,
    input  issue, system_stall, busy_mask,
    input  state, stall_cnt, deadlock_err, wb_err
  );

  modport slave (
    input  dec_valid, dec_rs1, dec_rs1_valid,
    input  dec_rs2, dec_rs2_valid,
    input  dec_rd, dec_rd_valid, dec_is_system,
    input  ex_stall, wb_valid, wb_rd,
    output issue, system_stall, busy_mask,
    output state, stall_cnt, deadlock_err, wb_err
  );

endinterface

// File: rtl/decode_hazard_ctrl_scoreboard.sv
// Pending-write bitmap with writeback bypass.
// A set in the same cycle as a clear wins.
module hazard_scoreboard
  import decode_hazard_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      i_clr_valid,
  input  reg_addr_t i_clr_addr,
  input  logic      i_set_valid,
  input  reg_addr_t i_set_addr,
  output reg_mask_t o_busy,
  output reg_mask_t o_eff_busy,
  output logic      o_bad_clr
);

  reg_mask_t r_busy;
  reg_mask_t w_clr;
  reg_mask_t w_next;

  always_comb begin
    w_clr = '0;
    if (i_clr_valid)
      w_clr[i_clr_addr] = 1'b1;
  end

  assign o_eff_busy = r_busy & ~w_clr;

  assign o_bad_clr = i_clr_valid &
                     (i_clr_addr != '0) &
                     ~r_busy[i_clr_addr];

  always_comb begin
    w_next = r_busy & ~w_clr;
    if (i_set_valid && i_set_addr != '0)
      w_next[i_set_addr] = 1'b1;
    w_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_busy <= '0;
    else
      r_busy <= w_next;
  end

  assign o_busy = r_busy;

endmodule

// File: rtl/decode_hazard_ctrl.sv
// Decode interlock: RAW/WAW/SYSTEM-drain hazards,
// stall FSM, stall counter and sticky error flags.
module decode_hazard_ctrl
  import decode_hazard_ctrl_pkg::*;
(
  input logic clk,
  input logic reset,
  decode_hazard_ctrl_if.slave bus
);

  localparam cnt_t LIMIT   = CNT_WIDTH'(STALL_LIMIT);
  localparam cnt_t CNT_MAX = '1;

  hz_state_e r_state, w_state_next;
  cnt_t      r_cnt, w_cnt_next;
  logic      r_deadlock, r_wb_err;

  reg_mask_t w_busy, w_eff;
  logic      w_bad_clr;
  logic      w_raw, w_waw, w_drain, w_any;
  logic      w_hazard, w_issue, w_sstall;

  hazard_scoreboard u_sb (
    .clk         (clk),
    .reset       (reset),
    .i_clr_valid (bus.wb_valid),
    .i_clr_addr  (bus.wb_rd),
    .i_set_valid (w_issue & bus.dec_rd_valid),
    .i_set_addr  (bus.dec_rd),
    .o_busy      (w_busy),
    .o_eff_busy  (w_eff),
    .o_bad_clr   (w_bad_clr)
  );

  assign w_any = |w_eff;

  assign w_raw = bus.dec_valid &
    ((bus.dec_rs1_valid & w_eff[bus.dec_rs1]) |
     (bus.dec_rs2_valid & w_eff[bus.dec_rs2]));

  assign w_waw = bus.dec_valid &
    bus.dec_rd_valid & w_eff[bus.dec_rd];

  assign w_drain = bus.dec_valid &
    bus.dec_is_system & w_any;

  assign w_hazard = w_raw | w_waw | w_drain;

  assign w_issue = bus.dec_valid & ~w_hazard &
    ~bus.ex_stall &
    ((r_state != HZ_DRAIN) | ~w_any);

  assign w_sstall = bus.dec_valid & ~w_issue;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      HZ_RUN: begin
        if (w_drain)
          w_state_next = HZ_DRAIN;
        else if (w_sstall)
          w_state_next = HZ_STALL;
      end
      HZ_STALL, HZ_DRAIN: begin
        if (!bus.dec_valid || w_issue)
          w_state_next = HZ_RUN;
      end
      default: w_state_next = HZ_RUN;
    endcase
  end

  always_comb begin
    w_cnt_next = '0;
    if (w_sstall)
      w_cnt_next = (r_cnt == CNT_MAX) ?
                   r_cnt : r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= HZ_RUN;
      r_cnt      <= '0;
      r_deadlock <= 1'b0;
      r_wb_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_cnt_next == LIMIT)
        r_deadlock <= 1'b1;
      if (w_bad_clr)
        r_wb_err <= 1'b1;
    end
  end

  assign bus.issue        = w_issue;
  assign bus.system_stall = w_sstall;
  assign bus.busy_mask    = w_busy;
  assign bus.state        = r_state;
  assign bus.stall_cnt    = r_cnt;
  assign bus.deadlock_err = r_deadlock;
  assign bus.wb_err       = r_wb_err;

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed-vector bench: stimulus queues expected
// responses, a negedge monitor pops and compares.
module tb_decode_hazard_ctrl;
  import decode_hazard_ctrl_pkg::*;

  logic clk;
  logic reset;

  decode_hazard_ctrl_if bus ();

  decode_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       iss;
    logic       ss;
    logic [1:0] st;
    logic [31:0] busy;
    logic [7:0] cnt;
    logic       dl;
    logic       we;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] RUN = 2'd0;
  localparam logic [1:0] STL = 2'd1;
  localparam logic [1:0] DRN = 2'd2;

  task automatic step(
    input logic rst, input logic v,
    input logic [4:0] rs1, input logic r1v,
    input logic [4:0] rs2, input logic r2v,
    input logic [4:0] rd, input logic rdv,
    input logic sys, input logic exs,
    input logic wbv, input logic [4:0] wbrd,
    input string name,
    input logic iss, input logic ss,
    input logic [1:0] st, input logic [31:0] busy,
    input logic [7:0] cnt,
    input logic dl, input logic we);
    exp_t e;
    @(posedge clk);
    #1;
    reset             = rst;
    bus.dec_valid     = v;
    bus.dec_rs1       = rs1;
    bus.dec_rs1_valid = r1v;
    bus.dec_rs2       = rs2;
    bus.dec_rs2_valid = r2v;
    bus.dec_rd        = rd;
    bus.dec_rd_valid  = rdv;
    bus.dec_is_system = sys;
    bus.ex_stall      = exs;
    bus.wb_valid      = wbv;
    bus.wb_rd         = wbrd;
    e.name = name; e.iss = iss; e.ss = ss;
    e.st = st; e.busy = busy; e.cnt = cnt;
    e.dl = dl; e.we = we;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_cmp++;
      if (bus.issue !== e.iss ||
          bus.system_stall !== e.ss ||
          bus.state !== e.st ||
          bus.busy_mask !== e.busy ||
          bus.stall_cnt !== e.cnt ||
          bus.deadlock_err !== e.dl ||
          bus.wb_err !== e.we) begin
        n_bad++;
        $display("FAIL %s: got iss=%0b ss=%0b st=%0d busy=%h cnt=%0d dl=%0b we=%0b, exp iss=%0b ss=%0b st=%0d busy=%h cnt=%0d dl=%0b we=%0b",
          e.name, bus.issue, bus.system_stall,
          bus.state, bus.busy_mask, bus.stall_cnt,
          bus.deadlock_err, bus.wb_err,
          e.iss, e.ss, e.st, e.busy, e.cnt,
          e.dl, e.we);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.dec_valid = 0; bus.dec_rs1 = 0;
    bus.dec_rs1_valid = 0; bus.dec_rs2 = 0;
    bus.dec_rs2_valid = 0; bus.dec_rd = 0;
    bus.dec_rd_valid = 0; bus.dec_is_system = 0;
    bus.ex_stall = 0; bus.wb_valid = 0;
    bus.wb_rd = 0;
    repeat (2) @(posedge clk);

    //   rst v rs1 v rs2 v rd v sys exs wbv wbrd
    step(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, "reset",
         0,0,RUN,32'h0,0,0,0);
    // RAW on x5 with writeback bypass
    step(0,1, 0,0, 0,0, 5,1, 0,0, 0,0, "raw_prod",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 5,1, 0,0, 0,0, 0,0, 0,0, "raw_stall",
         0,1,RUN,32'h20,0,0,0);
    step(0,1, 5,1, 0,0, 0,0, 0,0, 1,5, "raw_bypass",
         1,0,STL,32'h20,1,0,0);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, "raw_clear",
         0,0,RUN,32'h0,0,0,0);
    // WAW on x7, then same-cycle clear/set
    step(0,1, 0,0, 0,0, 7,1, 0,0, 0,0, "waw_prod",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 0,0, 0,0, 7,1, 0,0, 0,0, "waw_stall",
         0,1,RUN,32'h80,0,0,0);
    step(0,1, 0,0, 0,0, 7,1, 0,0, 1,7, "waw_setclr",
         1,0,STL,32'h80,1,0,0);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 1,7, "waw_setwins",
         0,0,RUN,32'h80,0,0,0);
    // x0 destination and unused busy source
    step(0,1, 0,0, 0,0, 0,1, 0,0, 0,0, "x0_issue",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 0,0, 0,0, 3,1, 0,0, 0,0, "x3_prod",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 1,1, 3,0, 0,0, 0,0, 0,0, "rs2_unused",
         1,0,RUN,32'h8,0,0,0);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 1,3, "x3_retire",
         0,0,RUN,32'h8,0,0,0);
    // SYSTEM drain of x2 and x9
    step(0,1, 0,0, 0,0, 2,1, 0,0, 0,0, "x2_prod",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 0,0, 0,0, 9,1, 0,0, 0,0, "x9_prod",
         1,0,RUN,32'h4,0,0,0);
    step(0,1, 0,0, 0,0, 0,0, 1,0, 0,0, "sys_enter",
         0,1,RUN,32'h204,0,0,0);
    step(0,1, 0,0, 0,0, 0,0, 1,0, 1,2, "sys_drain",
         0,1,DRN,32'h204,1,0,0);
    step(0,1, 0,0, 0,0, 0,0, 1,0, 1,9, "sys_issue",
         1,0,DRN,32'h200,2,0,0);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, "sys_done",
         0,0,RUN,32'h0,0,0,0);
    // back-pressure up to the deadlock limit
    for (int k = 0; k < 255; k++)
      step(0,1, 0,0, 0,0, 0,0, 0,1, 0,0, "bp_hold",
           0,1, (k == 0) ? RUN : STL, 32'h0,
           8'(k), 0,0);
    step(0,1, 0,0, 0,0, 0,0, 0,0, 0,0, "bp_release",
         1,0,STL,32'h0,255,1,0);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, "dl_sticky",
         0,0,RUN,32'h0,0,1,0);
    // writeback to a non-pending register
    step(0,0, 0,0, 0,0, 0,0, 0,0, 1,4, "wberr_cycle",
         0,0,RUN,32'h0,0,1,0);
    step(0,1, 0,0, 0,0, 6,1, 0,0, 0,0, "wberr_sticky",
         1,0,RUN,32'h0,0,1,1);
    // reset in the middle of a stall
    step(0,1, 6,1, 0,0, 0,0, 0,0, 0,0, "pre_rst_stall",
         0,1,RUN,32'h40,0,1,1);
    step(1,1, 6,1, 0,0, 0,0, 0,0, 0,0, "rst_assert",
         0,1,STL,32'h40,1,1,1);
    step(0,0, 0,0, 0,0, 0,0, 0,0, 0,0, "rst_clear",
         0,0,RUN,32'h0,0,0,0);
    step(0,1, 6,1, 0,0, 0,0, 0,0, 0,0, "post_rst_issue",
         1,0,RUN,32'h0,0,0,0);
    step(0,1, 0,0, 0,0, 0,0, 0,1, 0,0, "no_valid_gate",
         0,1,RUN,32'h0,0,0,0);
    step(0,0, 0,0, 0,0, 0,0, 0,1, 0,0, "valid_low",
         0,0,STL,32'h0,1,0,0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending, exp 0",
               q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
